// File: rtl/flag_bank.sv
// Parametrised condition-flag register with a per-bit write enable, a same-cycle bypass view and a LIFO save/restore stack.
// Latency: every operation takes one cycle. q_fwd shows the next q value combinationally, and q takes that value on the next edge.
// Backpressure: none. A push when full, a pop when empty, or a push and pop together leaves the stack unchanged and sets err.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   d        new flag values
//   wr_en    per-bit write enable; bit i gates d[i]
//   push     save the current q onto the stack
//   pop      restore q from the top of the stack
//   err_clr  synchronous clear of the sticky err flag
//   q        registered flags
//   q_fwd    combinational next-state view (bypass)
//   count    number of occupied stack entries
//   full     count == DEPTH
//   empty    count == 0
//   err      sticky flag for an illegal stack operation
module flag_bank #(
  parameter int              WIDTH     = 4,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           d,
  input  logic [WIDTH-1:0]           wr_en,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_fwd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);
  // The stack index is never wider than the count, so the low bits of the count address the array.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] wmerge;
  logic [CW-1:0]    count_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             pop_ok;
  logic             push_ok;
  logic             illegal;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  assign pop_ok  = pop & ~push & ~empty;
  assign push_ok = push & ~pop & ~full;
  assign illegal = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  assign count_m1 = count - CNT_ONE;
  assign top_idx  = count_m1[AW-1:0];
  assign wr_idx   = count[AW-1:0];

  always_comb begin
    wmerge = (wr_en & d) | (~wr_en & q);
    q_fwd  = wmerge;
    // A restore replaces the whole word, so the ALU write is dropped in that cycle.
    if (pop_ok) begin
      q_fwd = stack[top_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= RESET_VAL;
      count <= '0;
      err   <= 1'b0;
    end else begin
      q <= q_fwd;
      if (push_ok) begin
        count <= count + CNT_ONE;
      end else if (pop_ok) begin
        count <= count_m1;
      end
      // An illegal operation in the same cycle as err_clr still sets err.
      err <= illegal | (err & ~err_clr);
    end
  end

  // Stack contents after reset are don't-care, so the array needs no reset.
  // The saved word is the value of q before the same-cycle write.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack[wr_idx] <= q;
    end
  end

endmodule

// File: tb/tb_flag_bank.sv
// Directed test of flag_bank with the default parameters (WIDTH=4, DEPTH=2, RESET_VAL=0).
// Each step drives its inputs, checks q_fwd before the edge, then checks the registered state after the edge.
// The table covers writes, the stack round trip and the illegal cases; hand-written sequences cover async reset.
module tb_flag_bank;

  logic       clk;
  logic       reset;
  logic [3:0] d;
  logic [3:0] wr_en;
  logic       push;
  logic       pop;
  logic       err_clr;
  logic [3:0] q;
  logic [3:0] q_fwd;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       err;

  int total;
  int passed;

  flag_bank #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .reset(reset), .d(d), .wr_en(wr_en), .push(push), .pop(pop),
    .err_clr(err_clr), .q(q), .q_fwd(q_fwd), .count(count), .full(full),
    .empty(empty), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [3:0] wr;
    logic       push;
    logic       pop;
    logic       clr;
    logic [3:0] efwd;
    logic [3:0] eq;
    logic [1:0] ecnt;
    logic       eerr;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input logic [1:0] ecnt,
                           input logic eerr);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".count"}, 32'(count), 32'(ecnt));
    chk({tag, ".full"}, 32'(full), 32'(ecnt == 2'd2));
    chk({tag, ".empty"}, 32'(empty), 32'(ecnt == 2'd0));
    chk({tag, ".err"}, 32'(err), 32'(eerr));
  endtask

  task automatic drive(input logic [3:0] dv, input logic [3:0] wv, input logic pu,
                       input logic po, input logic cl);
    d = dv; wr_en = wv; push = pu; pop = po; err_clr = cl;
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    //             d        wr_en    push  pop   clr   q_fwd    q        cnt   err
    vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101, 2'd0, 1'b0};
    vecs[2]  = '{4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101, 2'd0, 1'b0};
    vecs[3]  = '{4'b1100, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b1100, 2'd0, 1'b0};
    vecs[4]  = '{4'b0011, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011, 2'd1, 1'b0};
    vecs[5]  = '{4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011, 2'd2, 1'b0};
    vecs[6]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0011, 2'd1, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b1100, 2'd0, 1'b0};
    vecs[8]  = '{4'b1010, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1010, 2'd0, 1'b1};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1010, 4'b1010, 2'd0, 1'b0};
    vecs[10] = '{4'b0110, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0110, 2'd1, 1'b0};
    vecs[11] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0110, 2'd2, 1'b0};
    vecs[12] = '{4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 2'd2, 1'b1};
    vecs[13] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd2, 1'b0};
    vecs[14] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0110, 4'b0110, 2'd1, 1'b0};
    vecs[15] = '{4'b1001, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b1001, 2'd1, 1'b1};
    vecs[16] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1001, 4'b1001, 2'd1, 1'b1};
    vecs[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1001, 4'b1001, 2'd1, 1'b0};
    vecs[18] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1010, 2'd0, 1'b0};

    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    chk_state("reset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].d, vecs[i].wr, vecs[i].push, vecs[i].pop, vecs[i].clr);
      #1;
      chk($sformatf("v%0d.q_fwd", i), 32'(q_fwd), 32'(vecs[i].efwd));
      @(posedge clk); #1;
      chk_state($sformatf("v%0d", i), vecs[i].eq, vecs[i].ecnt, vecs[i].eerr);
    end

    // Async reset mid-cycle with q=1010, then hold with wr_en=0.
    chk("pre_rst.q", 32'(q), 32'(4'b1010));
    drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk_state("async_rst", 4'b0000, 2'd0, 1'b0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d.q", i), 32'(q), 32'(4'b0000));
      chk($sformatf("hold%0d.q_fwd", i), 32'(q_fwd), 32'(4'b0000));
    end

    // Fill the stack with q=1111, then reset between edges.
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state("full2", 4'b1111, 2'd2, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk_state("rst_full", 4'b0000, 2'd0, 1'b0);
    @(negedge clk) reset = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1 chk("pop_after_rst.q_fwd", 32'(q_fwd), 32'(4'b0000));
    @(posedge clk); #1;
    chk_state("pop_after_rst", 4'b0000, 2'd0, 1'b1);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/flag_bank.md
Name: flag_bank

Overview:
- Parametrised condition-flag register; successor to the single-bit enabled flag flop.
- Holds WIDTH flags (default NZCV, bit 3 = N … bit 0 = C/V order below) with a per-flag write enable.
- Provides a same-cycle bypass view for the consumer in the executing stage.
- Includes a DEPTH-entry save/restore stack so flags survive an exception/call and are restored on return.

Parameters:
- WIDTH, 4, number of flag bits (bit 3 N, bit 2 Z, bit 1 C, bit 0 V when 4).
- DEPTH, 2, save-stack entries; must be ≥ 1.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- d  input  WIDTH  new flag values from ALU.
- wr_en  input  WIDTH  per-bit write enable; bit i gates d[i].
- push  input  1  save current q onto stack.
- pop  input  1  restore q from stack top.
- err_clr  input  1  synchronous clear of sticky err.
- q  output  WIDTH  registered flags.
- q_fwd  output  WIDTH  combinational next-state view (bypass).
- count  output  $clog2(DEPTH+1)  occupied stack entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- err  output  1  sticky illegal-stack-operation flag.

Behaviour:
- Reset (async, any time, including mid push/pop):
  - q = RESET_VAL; count = 0; empty = 1; full = 0; err = 0.
  - Stack contents are don't-care.
- Definitions:
  - wmerge[i] = wr_en[i] ? d[i] : q[i].
  - pop_ok = pop & ~push & ~empty.
  - push_ok = push & ~pop & ~full.
- Next q each rising edge:
  - If pop_ok: stack[count-1] (whole word; wr_en ignored that cycle).
  - Otherwise: wmerge.
  - wr_en = 0 and no pop_ok → q holds (equivalent to the old single-flag enable flop per bit).
- q_fwd = next q value as defined above, purely combinational; zero-latency bypass. q reflects the same value one cycle later.
- push_ok:
  - stack[count] <= q (pre-update value, not wmerge); count <= count+1.
  - The same-cycle write still updates q.
- pop_ok: count <= count-1; q <= popped word.
- Illegal cases (no stack or count change; write still applies to q via wmerge; err <= 1):
  - Push when full.
  - Pop when empty.
  - Push and pop asserted together (regardless of occupancy).
- err:
  - Sticky once set.
  - err_clr clears it next edge unless an illegal operation occurs in that same cycle, in which case set wins.
- full/empty: derived combinationally from registered count; valid from reset.
- Stack is LIFO:
  - Entry index 0 is oldest.
  - DEPTH consecutive pushes then DEPTH pops return words in reverse order.
- Single-cycle latency for every operation; no back-pressure, no handshake beyond the above.

Test Plan:
- Reset/hold: assert reset mid-cycle with q=4'b1010 → q=0000, count=0, empty=1, err=0 immediately. Hold wr_en=0, d=1111 for 4 cycles → q stays 0000.
- Per-bit write: q=0000, d=1111, wr_en=0101 → q_fwd=0101 same cycle, q=0101 next edge. Then wr_en=1000, d=0000 → q=0101 (bit 3 already 0), q_fwd matches.
- Push/pop round trip (DEPTH=2):
  - q=1100; push with d=0011, wr_en=1111 → stack[0]=1100, q=0011, count=1.
  - Push again → stack[1]=0011, count=2, full=1.
  - Pop with wr_en=1111, d=1111 → q=0011 (write ignored), count=1.
  - Pop → q=1100, count=0, empty=1.
- Overflow/underflow:
  - Third push when full → count stays 2, err=1.
  - Pop when empty with d=1010, wr_en=1111 → q=1010, count=0, err=1.
  - err_clr → err=0 next edge.
- Simultaneous push+pop with count=1, q=0110, d=1001, wr_en=1111 → count=1, stack unchanged, q=1001, err=1. With err_clr also high → err=1 (set wins).
- Reset mid-sequence: count=2, q=1111, assert reset between edges → q=RESET_VAL, count=0, full=0 at once. First pop after release → err=1, q unchanged.
